axis_stream_checker: RTL and testbench

Synthesisable AXI4-Stream sink that generalises the team's VIP-based stream check into RTL. It accepts a multi-channel stream, generates its own TREADY pattern, and checks every beat against the counting-packet pattern our stream sources emit: top byte equals the beat index, all other bytes zero, TLAST on the final beat. It sits at the end of a datapath under test, in simulation or on hardware, and exposes sticky error flags and saturating statistics.

---
 rtl/axis_chk_pkg.sv | 26 ++
 rtl/axis_stream_checker_ready_gen.sv | 66 ++++++
 rtl/axis_stream_checker.sv | 137 +++++++++++++
 tb/tb_axis_stream_checker.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// axis_chk_pkg: shared types and helpers for the AXI4-Stream pattern checker.
//   ready_policy_t : TREADY generation policy (code 3 behaves as NEVER)
//   ERR_*          : bit positions inside err_flags
//   sat_inc        : saturating increment for counters up to 32 bits wide
package axis_chk_pkg;

  typedef enum logic [1:0] {
    ALWAYS = 2'd0,
    OSC    = 2'd1,
    NEVER  = 2'd2
  } ready_policy_t;

  localparam int ERR_DATA      = 0;
  localparam int ERR_EARLY_LAST = 1;
  localparam int ERR_NO_LAST   = 2;
  localparam int ERR_DEST      = 3;
  localparam int NUM_ERR       = 4;

  // v is the counter zero-extended to 32 bits, w its real width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max;
    max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_stream_checker_ready_gen.sv
// axis_chk_ready_gen: registered TREADY generator.
//   clk, rst        : clock, async active-high reset
//   policy          : ALWAYS / OSC / NEVER (3 = NEVER)
//   low_time        : OSC low phase length in cycles (0 acts as 1)
//   high_time       : OSC high phase length in cycles (0 acts as 1)
//   ready           : registered TREADY
module axis_chk_ready_gen
  import axis_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] policy,
  input  logic [7:0] low_time,
  input  logic [7:0] high_time,
  output logic       ready
);

  logic       started;   // first edge after reset only arms the generator
  logic [1:0] prev_pol;
  logic [7:0] cnt;       // cycles already spent in the current OSC phase
  logic [7:0] lo_len, hi_len, cur_len;

  assign lo_len  = (low_time  == 8'd0) ? 8'd1 : low_time;
  assign hi_len  = (high_time == 8'd0) ? 8'd1 : high_time;
  assign cur_len = ready ? hi_len : lo_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started  <= 1'b0;
      prev_pol <= 2'd0;
      cnt      <= 8'd0;
      ready    <= 1'b0;
    end else begin
      prev_pol <= policy;
      if (!started) begin
        started <= 1'b1;
        cnt     <= 8'd0;
        ready   <= 1'b0;
      end else begin
        case (policy)
          ALWAYS: begin
            ready <= 1'b1;
            cnt   <= 8'd0;
          end
          OSC: begin
            // entering OSC (or any policy switch) restarts in the low phase
            if (policy != prev_pol) begin
              ready <= 1'b0;
              cnt   <= 8'd0;
            end else if (cnt >= cur_len - 8'd1) begin
              ready <= ~ready;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            ready <= 1'b0;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: AXI4-Stream sink checking the counting-packet pattern
// (top byte = beat index, other bytes zero, TLAST on beat PKT_LEN-1).
//   aclk, areset           : clock, async active-high reset
//   s_axis_*               : stream sink; tready is registered
//   ready_policy, low_time, high_time : TREADY generation control
//   clr_stats              : sync clear of counters, flags, beat indices
//   pkt_done, pkt_done_ch  : one-cycle pulse + channel per completed packet
//   err_flags              : sticky {dest, no_last, early_last, data}
//   beat_cnt, pkt_cnt, err_cnt : saturating statistics
// Handshakes are captured in one register stage and checked on the next
// edge, so results appear one cycle after the handshake.
module axis_stream_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int NUM_CH  = 2,
  parameter int DEST_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic [DEST_W-1:0] s_axis_tdest,
  input  logic [1:0]        ready_policy,
  input  logic [7:0]        low_time,
  input  logic [7:0]        high_time,
  input  logic              clr_stats,
  output logic              pkt_done,
  output logic [DEST_W-1:0] pkt_done_ch,
  output logic [NUM_ERR-1:0] err_flags,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(32'(v), CNT_W));
  endfunction

  axis_chk_ready_gen u_ready (
    .clk       (aclk),
    .rst       (areset),
    .policy    (ready_policy),
    .low_time  (low_time),
    .high_time (high_time),
    .ready     (s_axis_tready)
  );

  // capture stage
  logic              hs, q_vld, q_last;
  logic [DATA_W-1:0] q_data;
  logic [DEST_W-1:0] q_dest;

  assign hs = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      q_vld  <= 1'b0;
      q_last <= 1'b0;
      q_data <= '0;
      q_dest <= '0;
    end else begin
      q_vld <= hs;
      if (hs) begin
        q_data <= s_axis_tdata;
        q_last <= s_axis_tlast;
        q_dest <= s_axis_tdest;
      end
    end
  end

  // check stage
  logic [NUM_CH-1:0][7:0] idx, idx_nxt;
  logic [7:0]             cur_idx;
  logic [DATA_W-1:0]      exp_data;
  logic                   dest_ok, is_last, done, beat_err;
  logic [NUM_ERR-1:0]     ev_flags;

  always_comb begin
    dest_ok = 32'(q_dest) < NUM_CH;
    cur_idx = 8'd0;
    for (int c = 0; c < NUM_CH; c++)
      if (32'(q_dest) == c) cur_idx = idx[c];
    exp_data = '0;
    exp_data[DATA_W-1 -: 8] = cur_idx;
    is_last = (cur_idx == LAST_IDX);
    done    = q_last | is_last;
    ev_flags = '0;
    ev_flags[ERR_DATA]       = dest_ok & (q_data != exp_data);
    ev_flags[ERR_EARLY_LAST] = dest_ok & q_last & ~is_last;
    ev_flags[ERR_NO_LAST]    = dest_ok & ~q_last & is_last;
    ev_flags[ERR_DEST]       = ~dest_ok;
    beat_err = |ev_flags;
    // clear first, then apply this cycle's beat
    idx_nxt = clr_stats ? '0 : idx;
    if (q_vld && dest_ok)
      for (int c = 0; c < NUM_CH; c++)
        if (32'(q_dest) == c) idx_nxt[c] = done ? 8'd0 : 8'(cur_idx + 8'd1);
  end

  logic [CNT_W-1:0]   beat_base, pkt_base, err_base;
  logic [NUM_ERR-1:0] flags_base;
  logic               ok_beat;

  assign beat_base  = clr_stats ? '0 : beat_cnt;
  assign pkt_base   = clr_stats ? '0 : pkt_cnt;
  assign err_base   = clr_stats ? '0 : err_cnt;
  assign flags_base = clr_stats ? '0 : err_flags;
  assign ok_beat    = q_vld & dest_ok;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      idx         <= '0;
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      err_cnt     <= '0;
      err_flags   <= '0;
      pkt_done    <= 1'b0;
      pkt_done_ch <= '0;
    end else begin
      idx       <= idx_nxt;
      beat_cnt  <= ok_beat ? inc(beat_base) : beat_base;
      pkt_cnt   <= (ok_beat && done) ? inc(pkt_base) : pkt_base;
      err_cnt   <= (q_vld && beat_err) ? inc(err_base) : err_base;
      err_flags <= flags_base | (q_vld ? ev_flags : '0);
      pkt_done  <= ok_beat & done;
      if (ok_beat && done) pkt_done_ch <= q_dest;
    end
  end

endmodule

// File: tb/tb_axis_stream_checker.sv
module tb_axis_stream_checker;
  import axis_chk_pkg::*;

  localparam int DATA_W = 64, NUM_CH = 2, DEST_W = 2, PKT_LEN = 8, CNT_W = 4;

  logic              aclk = 1'b0, areset = 1'b1;
  logic              s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [DEST_W-1:0] s_axis_tdest = '0;
  logic [1:0]        ready_policy = ALWAYS;
  logic [7:0]        low_time = 8'd1, high_time = 8'd1;
  logic              clr_stats = 1'b0, pkt_done;
  logic [DEST_W-1:0] pkt_done_ch;
  logic [3:0]        err_flags;
  logic [CNT_W-1:0]  beat_cnt, pkt_cnt, err_cnt;

  axis_stream_checker #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEST_W(DEST_W),
                        .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdest(s_axis_tdest),
    .ready_policy(ready_policy), .low_time(low_time), .high_time(high_time),
    .clr_stats(clr_stats), .pkt_done(pkt_done), .pkt_done_ch(pkt_done_ch),
    .err_flags(err_flags), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt));

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0, done_seen = 0;
  int sb[$];
  int mdl[NUM_CH];

  // scoreboard: every pkt_done pulse pops the expected channel
  always @(negedge aclk) begin
    if (!areset && pkt_done) begin
      done_seen++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pkt_done_unexpected got ch=%0d, none expected", pkt_done_ch);
      end else begin
        int e;
        e = sb.pop_front();
        if (int'(pkt_done_ch) !== e) begin
          n_err++;
          $display("FAIL pkt_done_ch got %0d exp %0d", pkt_done_ch, e);
        end
      end
    end
  end

  task automatic drive(input int ch, input logic [7:0] top, input logic last);
    logic [DATA_W-1:0] d;
    d = '0;
    d[DATA_W-1 -: 8] = top;
    s_axis_tdata  = d;
    s_axis_tdest  = DEST_W'(ch);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic model(input int ch, input logic last);
    if (ch < NUM_CH) begin
      if (last || mdl[ch] == PKT_LEN - 1) begin
        sb.push_back(ch);
        mdl[ch] = 0;
      end else mdl[ch]++;
    end
  endtask

  // entered and left at a negedge; returns right after the handshake edge
  task automatic send(input int ch, input logic [7:0] top, input logic last);
    int n = 0;
    drive(ch, top, last);
    while (!s_axis_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout ch=%0d tready stuck at %0b", ch, s_axis_tready);
    end else model(ch, last);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_good(input int ch);
    send(ch, 8'(mdl[ch]), mdl[ch] == PKT_LEN - 1);
  endtask

  task automatic settle();
    repeat (2) @(negedge aclk);
  endtask

  task automatic do_clr();
    clr_stats = 1'b1;
    @(negedge aclk);
    clr_stats = 1'b0;
    done_seen = 0;
    for (int c = 0; c < NUM_CH; c++) mdl[c] = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    n_cmp++;
    if ({s_axis_tready, pkt_done, pkt_done_ch, err_flags} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl got rdy=%0b done=%0b ch=%0d flags=%b exp all 0",
               s_axis_tready, pkt_done, pkt_done_ch, err_flags);
    end
    n_cmp++;
    if ({beat_cnt, pkt_cnt, err_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_cnts got %0d/%0d/%0d exp 0/0/0", beat_cnt, pkt_cnt, err_cnt);
    end
    areset = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_edge1 got %0b exp 0", s_axis_tready);
    end
    @(negedge aclk);
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_edge2 got %0b exp 1", s_axis_tready);
    end
  endtask

  task automatic test_basic();
    for (int b = 0; b < 8; b++) send_good(0);
    settle();
    n_cmp++;
    if (done_seen !== 1 || beat_cnt !== 4'd8 || pkt_cnt !== 4'd1 || err_flags !== 4'b0) begin
      n_err++;
      $display("FAIL basic got done=%0d beat=%0d pkt=%0d flags=%b exp 1/8/1/0000",
               done_seen, beat_cnt, pkt_cnt, err_flags);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_clr();
    t0 = cyc;
    for (int b = 0; b < 8; b++) send_good(1);
    n_cmp++;
    if (cyc - t0 !== 8) begin
      n_err++;
      $display("FAIL b2b_cycles got %0d exp 8", cyc - t0);
    end
    settle();
    n_cmp++;
    if (pkt_cnt !== 4'd1 || err_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_cnts got pkt=%0d err=%0d exp 1/0", pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_osc();
    int b = 0, bad = 0;
    logic exp_rdy;
    do_clr();
    s_axis_tvalid = 1'b0;
    ready_policy = OSC; low_time = 8'd2; high_time = 8'd6;
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      exp_rdy = (i % 8) >= 2;
      n_cmp++;
      if (s_axis_tready !== exp_rdy) begin
        n_err++; bad++;
        $display("FAIL osc_pattern cyc%0d got %0b exp %0b", i, s_axis_tready, exp_rdy);
      end
      if (b < 8) begin
        drive(0, 8'(b), b == 7);
        if (s_axis_tready) begin
          model(0, b == 7);
          b++;
        end
      end else s_axis_tvalid = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    ready_policy = ALWAYS;
    settle();
    n_cmp++;
    if (b !== 8 || beat_cnt !== 4'd8 || pkt_cnt !== 4'd1 || err_flags !== 4'b0) begin
      n_err++;
      $display("FAIL osc_result got beats=%0d cnt=%0d pkt=%0d flags=%b exp 8/8/1/0000",
               b, beat_cnt, pkt_cnt, err_flags);
    end
  endtask

  task automatic test_interleave();
    do_clr();
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++) send_good(c);
    settle();
    n_cmp++;
    if (pkt_cnt !== 4'd4 || err_cnt !== 4'd0 || done_seen !== 4) begin
      n_err++;
      $display("FAIL interleave got pkt=%0d err=%0d done=%0d exp 4/0/4",
               pkt_cnt, err_cnt, done_seen);
    end
  endtask

  task automatic test_data_err();
    do_clr();
    for (int b = 0; b < 3; b++) send_good(0);
    send(0, 8'h05, 1'b0);
    n_cmp++;
    if (err_flags !== 4'b0000) begin
      n_err++;
      $display("FAIL data_err_latency got %b exp 0000", err_flags);
    end
    @(negedge aclk);
    n_cmp++;
    if (err_flags !== 4'b0001 || err_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL data_err_flag got flags=%b err=%0d exp 0001/1", err_flags, err_cnt);
    end
    while (mdl[0] != 0) send_good(0);
    settle();
    n_cmp++;
    if (pkt_cnt !== 4'd1 || err_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL data_err_pkt got pkt=%0d err=%0d exp 1/1", pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_early_last();
    do_clr();
    for (int b = 0; b < 4; b++) send_good(0);
    send(0, 8'd4, 1'b1);
    for (int b = 0; b < 8; b++) send_good(0);
    settle();
    n_cmp++;
    if (err_flags !== 4'b0010 || err_cnt !== 4'd1 || pkt_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL early_last got flags=%b err=%0d pkt=%0d exp 0010/1/2",
               err_flags, err_cnt, pkt_cnt);
    end
  endtask

  task automatic test_no_last();
    do_clr();
    for (int b = 0; b < 7; b++) send_good(0);
    send(0, 8'd7, 1'b0);
    settle();
    n_cmp++;
    if (err_flags !== 4'b0100 || err_cnt !== 4'd1 || pkt_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL no_last got flags=%b err=%0d pkt=%0d exp 0100/1/1",
               err_flags, err_cnt, pkt_cnt);
    end
  endtask

  task automatic test_bad_dest();
    do_clr();
    send(3, 8'd0, 1'b0);
    settle();
    n_cmp++;
    if (err_flags !== 4'b1000 || beat_cnt !== 4'd0 || err_cnt !== 4'd1 || pkt_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL bad_dest got flags=%b beat=%0d err=%0d pkt=%0d exp 1000/0/1/0",
               err_flags, beat_cnt, err_cnt, pkt_cnt);
    end
    send_good(0);
    settle();
    n_cmp++;
    if (err_flags !== 4'b1000 || beat_cnt !== 4'd1 || err_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL bad_dest_after got flags=%b beat=%0d err=%0d exp 1000/1/1",
               err_flags, beat_cnt, err_cnt);
    end
  endtask

  task automatic test_saturate();
    do_clr();
    for (int b = 0; b < 20; b++) send_good(1);
    settle();
    n_cmp++;
    if (beat_cnt !== 4'hF || pkt_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL saturate got beat=%0d pkt=%0d exp 15/2", beat_cnt, pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_clr();
    for (int b = 0; b < 3; b++) send_good(0);
    areset = 1'b1;
    #1;
    n_cmp++;
    if ({s_axis_tready, pkt_done, pkt_done_ch, err_flags, beat_cnt, pkt_cnt, err_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_mid got rdy=%0b flags=%b cnts=%0d/%0d/%0d exp all 0",
               s_axis_tready, err_flags, beat_cnt, pkt_cnt, err_cnt);
    end
    sb.delete();
    for (int c = 0; c < NUM_CH; c++) mdl[c] = 0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    clr_stats = 1'b1;
    send(0, 8'h09, 1'b0);
    @(negedge aclk);
    clr_stats = 1'b0;
    settle();
    n_cmp++;
    if (err_cnt !== 4'd1 || err_flags !== 4'b0001 || beat_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL reset_clr_err got err=%0d flags=%b beat=%0d exp 1/0001/1",
               err_cnt, err_flags, beat_cnt);
    end
    send_good(1);
    settle();
    n_cmp++;
    if (err_cnt !== 4'd1 || beat_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL reset_idx0 got err=%0d beat=%0d exp 1/2", err_cnt, beat_cnt);
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) mdl[c] = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_osc();
    test_interleave();
    test_data_err();
    test_early_last();
    test_no_last();
    test_bad_dest();
    test_saturate();
    test_reset_mid();
    settle();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d pending exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
